scsi_xfer_seq: RTL and testbench

- Parametrised SCSI bus-cycle sequencer that generates the SCSI-side control strobes, data-path steering and FIFO/byte-pointer increments.
- Replaces a fixed decode of hard-coded state terms with an explicit state machine, programmable setup/strobe/hold timing and a configurable FIFO word width.
- Arbitrates CPU register accesses to the SCSI controller against DREQ-driven DMA byte transfers to and from the FIFO.

---
 rtl/scsi_xfer_seq.sv | 119 +++++++++++
 tb/tb_scsi_xfer_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/scsi_xfer_seq.sv
// scsi_xfer_seq: SCSI bus-cycle sequencer for CPU register accesses and DREQ-driven DMA byte transfers.
// Ports:
//   CLK, nRST                    clock (rising edge), asynchronous active-low reset
//   CPUREQ, RW                   CPU register access request and direction (1 = read SCSI)
//   DMAENA, DMADIR, DREQ_        DMA enable, direction (1 = SCSI to FIFO), active-low DMA request
//   FIFOFULL, FIFOEMPTY          FIFO flow-control status
//   SCSI_CS, DACK, RE, WE        SCSI-side select/acknowledge and read/write strobes
//   S2CPU, CPU2S, S2F, F2S       data-path steering
//   SET_DSACK, INCBO, INCNI, INCNO  one-cycle completion/increment pulses
//   BO                           current FIFO byte lane
//   BUSY                         sequencer not idle
module scsi_xfer_seq #(
    parameter int SETUP_CYC      = 1,
    parameter int STRB_CYC       = 2,
    parameter int HOLD_CYC       = 1,
    parameter int BYTES_PER_WORD = 4,
    parameter int BO_W           = $clog2(BYTES_PER_WORD)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            CPUREQ,
    input  logic            RW,
    input  logic            DMAENA,
    input  logic            DMADIR,
    input  logic            DREQ_,
    input  logic            FIFOFULL,
    input  logic            FIFOEMPTY,
    output logic            SCSI_CS,
    output logic            DACK,
    output logic            RE,
    output logic            WE,
    output logic            S2CPU,
    output logic            CPU2S,
    output logic            S2F,
    output logic            F2S,
    output logic            SET_DSACK,
    output logic            INCBO,
    output logic            INCNI,
    output logic            INCNO,
    output logic [BO_W-1:0] BO,
    output logic            BUSY
);
    typedef enum logic [2:0] {
        IDLE, CPU_SETUP, CPU_STRB, CPU_HOLD, DMA_SETUP, DMA_STRB, DMA_HOLD
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STRB_LD  = 4'(STRB_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       cyc_rd, cyc_rd_nx, cyc_dir, cyc_dir_nx;
    logic       last, dma_ok, wrap, cpu, dma;

    assign last   = cnt == 4'd0;
    assign dma_ok = DMAENA & ~DREQ_ & (DMADIR ? ~FIFOFULL : ~FIFOEMPTY);
    assign wrap   = BO == BO_W'(BYTES_PER_WORD - 1);

    always_comb begin
        state_nx   = state;
        cnt_nx     = last ? cnt : cnt - 4'd1;
        cyc_rd_nx  = cyc_rd;
        cyc_dir_nx = cyc_dir;
        case (state)
            IDLE:
                if (CPUREQ) begin
                    state_nx  = CPU_SETUP;
                    cnt_nx    = SETUP_LD;
                    cyc_rd_nx = RW;
                end else if (dma_ok) begin
                    state_nx   = DMA_SETUP;
                    cnt_nx     = SETUP_LD;
                    cyc_dir_nx = DMADIR;
                end
            CPU_SETUP: if (last) begin state_nx = CPU_STRB; cnt_nx = STRB_LD; end
            CPU_STRB:  if (last) begin state_nx = CPU_HOLD; cnt_nx = HOLD_LD; end
            CPU_HOLD:  if (last) state_nx = IDLE;
            DMA_SETUP: if (last) begin state_nx = DMA_STRB; cnt_nx = STRB_LD; end
            DMA_STRB:  if (last) begin state_nx = DMA_HOLD; cnt_nx = HOLD_LD; end
            DMA_HOLD:  if (last) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            cyc_rd  <= 1'b0;
            cyc_dir <= 1'b0;
            BO      <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            cyc_rd  <= cyc_rd_nx;
            cyc_dir <= cyc_dir_nx;
            // A partial word is dropped when DMA is disabled while idle.
            BO      <= INCBO ? (wrap ? '0 : BO + 1'b1) :
                       (state == IDLE && !DMAENA) ? '0 : BO;
        end
    end

    assign cpu       = state inside {CPU_SETUP, CPU_STRB, CPU_HOLD};
    assign dma       = state inside {DMA_SETUP, DMA_STRB, DMA_HOLD};
    assign SCSI_CS   = cpu;
    assign DACK      = dma;
    assign RE        = (state == CPU_STRB & cyc_rd) | (state == DMA_STRB & cyc_dir);
    assign WE        = (state == CPU_STRB & ~cyc_rd) | (state == DMA_STRB & ~cyc_dir);
    assign CPU2S     = cpu & ~cyc_rd;
    assign S2CPU     = cyc_rd & (state == CPU_STRB | state == CPU_HOLD);
    assign F2S       = dma & ~cyc_dir;
    assign S2F       = cyc_dir & (state == DMA_STRB | state == DMA_HOLD);
    assign SET_DSACK = state == CPU_HOLD & last;
    assign INCBO     = state == DMA_HOLD & last;
    assign INCNI     = INCBO & wrap & cyc_dir;
    assign INCNO     = INCBO & wrap & ~cyc_dir;
    assign BUSY      = state != IDLE;
endmodule

// File: tb/tb_scsi_xfer_seq.sv
// tb_scsi_xfer_seq: directed self-checking bench for scsi_xfer_seq (default timing plus a 3/1/2 timing instance).
module tb_scsi_xfer_seq;
    logic CLK = 1'b0, nRST = 1'b0, CPUREQ = 1'b0, RW = 1'b0, DMAENA = 1'b0, DMADIR = 1'b0;
    logic DREQ_ = 1'b1, FIFOFULL = 1'b0, FIFOEMPTY = 1'b0, req2 = 1'b0;
    logic SCSI_CS, DACK, RE, WE, S2CPU, CPU2S, S2F, F2S, SET_DSACK, INCBO, INCNI, INCNO, BUSY;
    logic [1:0] BO;
    logic cs2, dack2, re2, we2, s2cpu2, cpu2s2, s2f2, f2s2, dsack2, incbo2, incni2, incno2, busy2;
    logic [1:0] bo2;
    int passed = 0, fails = 0, total = 0;
    int nb, ni, no, ovl;
    logic [7:0] ea [5];
    logic [4:0] eb [5];
    logic [4:0] ef [7];

    scsi_xfer_seq dut (
        .CLK(CLK), .nRST(nRST), .CPUREQ(CPUREQ), .RW(RW), .DMAENA(DMAENA), .DMADIR(DMADIR),
        .DREQ_(DREQ_), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY),
        .SCSI_CS(SCSI_CS), .DACK(DACK), .RE(RE), .WE(WE), .S2CPU(S2CPU), .CPU2S(CPU2S),
        .S2F(S2F), .F2S(F2S), .SET_DSACK(SET_DSACK), .INCBO(INCBO), .INCNI(INCNI),
        .INCNO(INCNO), .BO(BO), .BUSY(BUSY)
    );

    scsi_xfer_seq #(.SETUP_CYC(3), .STRB_CYC(1), .HOLD_CYC(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .CPUREQ(req2), .RW(1'b0), .DMAENA(1'b0), .DMADIR(1'b0),
        .DREQ_(1'b1), .FIFOFULL(1'b0), .FIFOEMPTY(1'b1),
        .SCSI_CS(cs2), .DACK(dack2), .RE(re2), .WE(we2), .S2CPU(s2cpu2), .CPU2S(cpu2s2),
        .S2F(s2f2), .F2S(f2s2), .SET_DSACK(dsack2), .INCBO(incbo2), .INCNI(incni2),
        .INCNO(incno2), .BO(bo2), .BUSY(busy2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        ea = '{8'b1000_0001, 8'b1101_0001, 8'b1101_0001, 8'b1001_0101, 8'h00};
        eb = '{5'b10011, 5'b10111, 5'b10111, 5'b10011, 5'b00000};
        ef = '{5'b10100, 5'b10100, 5'b10100, 5'b11100, 5'b10100, 5'b10110, 5'b00000};
        #1;
        chk("reset outs", {SCSI_CS, DACK, RE, WE, S2CPU, CPU2S, S2F, F2S, SET_DSACK, INCBO, INCNI, INCNO, BUSY}, 0);
        chk("reset bo", BO, 0);
        tick;
        tick;
        nRST = 1'b1;
        tick;
        // CPU read, default timing
        CPUREQ = 1'b1;
        RW = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk($sformatf("cpu_rd c%0d", i + 1), {SCSI_CS, RE, WE, S2CPU, CPU2S, SET_DSACK, DACK, BUSY}, ea[i]);
            if (i == 0) CPUREQ = 1'b0;
        end
        // CPU write and DMA request in the same idle cycle: CPU first
        CPUREQ = 1'b1;
        RW = 1'b0;
        DMAENA = 1'b1;
        DMADIR = 1'b1;
        DREQ_ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk($sformatf("arb c%0d", i + 1), {SCSI_CS, DACK, WE, CPU2S, BUSY}, eb[i]);
            if (i == 0) CPUREQ = 1'b0;
        end
        // Eight SCSI->FIFO bytes follow
        nb = 0; ni = 0; no = 0; ovl = 0;
        for (int i = 6; i <= 45; i++) begin
            tick;
            if (i == 6) chk("dma after cpu", {SCSI_CS, DACK, S2F, F2S}, 4'b0100);
            ovl += int'(SCSI_CS & DACK) + int'(RE & WE);
            if (INCBO) begin
                chk($sformatf("bo at incbo %0d", nb), BO, nb % 4);
                chk($sformatf("incni at incbo %0d", nb), INCNI, nb % 4 == 3);
                nb++;
            end
            ni += int'(INCNI);
            no += int'(INCNO);
            if (i == 41) DREQ_ = 1'b1;
        end
        chk("s2f incbo count", nb, 8);
        chk("s2f incni count", ni, 2);
        chk("s2f incno count", no, 0);
        chk("overlap count", ovl, 0);
        chk("s2f final bo", BO, 0);
        chk("s2f final busy", BUSY, 0);
        // FIFO->SCSI held off by empty FIFO
        DMADIR = 1'b0;
        FIFOEMPTY = 1'b1;
        DREQ_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("empty hold c%0d", i), {DACK, BUSY}, 0);
        end
        FIFOEMPTY = 1'b0;
        nb = 0; ni = 0; no = 0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (i == 1) chk("f2s setup", {DACK, F2S, WE, S2F}, 4'b1100);
            if (i == 2) chk("f2s strb", {DACK, F2S, WE, S2F}, 4'b1110);
            if (INCNO) chk("incno cycle", i, 19);
            nb += int'(INCBO);
            ni += int'(INCNI);
            no += int'(INCNO);
            if (i == 16) DREQ_ = 1'b1;
        end
        chk("f2s incbo count", nb, 4);
        chk("f2s incno count", no, 1);
        chk("f2s incni count", ni, 0);
        // Reset in the middle of DMA_STRB with BO=2
        DMADIR = 1'b1;
        DREQ_ = 1'b0;
        for (int i = 1; i <= 12; i++) tick;
        chk("pre-reset strb", {DACK, RE, S2F}, 3'b111);
        chk("pre-reset bo", BO, 2);
        #1 nRST = 1'b0;
        #1;
        chk("async reset outs", {SCSI_CS, DACK, RE, WE, S2CPU, CPU2S, S2F, F2S, SET_DSACK, INCBO, INCNI, INCNO, BUSY}, 0);
        chk("async reset bo", BO, 0);
        DREQ_ = 1'b1;
        DMAENA = 1'b0;
        tick;
        chk("in reset incbo", {INCBO, BUSY}, 0);
        nRST = 1'b1;
        tick;
        // CPU write with 3/1/2 timing; request dropped early
        req2 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick;
            chk($sformatf("slow wr c%0d", i + 1), {cs2, we2, cpu2s2, dsack2, re2}, ef[i]);
            if (i == 1) req2 = 1'b0;
        end
        chk("slow wr idle main", BUSY, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
